// File: rtl/ram_access_ctrl_if.sv
// RAM-side bus of the MEM-stage data RAM initiator.
// Handshake: the master raises ram_en with ram_addr, ram_write_en and
// ram_write_data, and holds all four stable until the slave returns a
// single-cycle ram_ack pulse. ram_read_data is only meaningful in the ack
// cycle. ram_en drops on the cycle after the ack, or after a timeout.
interface ram_access_ctrl_if;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic        ram_ack;
  logic [31:0] ram_read_data;

  modport master (
    output ram_en, ram_write_en, ram_addr, ram_write_data,
    input  ram_ack, ram_read_data
  );

  modport slave (
    input  ram_en, ram_write_en, ram_addr, ram_write_data,
    output ram_ack, ram_read_data
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// MEM-stage data RAM initiator: issues one RAM transaction per load/store,
// stalls the pipeline until ack (or timeout) and latches load data for WB.
// Optional feature macro: RAM_HALF_EN makes mem_sel 4'b0011 a legal
// halfword access; without it 4'b0011 is treated as an illegal size.
module ram_access_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_read_flag,
  input  logic                    mem_write_flag,
  input  logic [3:0]              mem_sel,
  input  logic [31:0]             address,
  input  logic [31:0]             mem_write_data,
  input  logic                    flush,
  ram_access_ctrl_if.master       ram,
  output logic [31:0]             load_data,
  output logic                    stall_req,
  output logic                    adel,
  output logic                    ades,
  output logic                    bus_error,
  output logic [1:0]              dbg_state
);

  // Counter only needs to reach ACK_TIMEOUT-1 before the timeout fires.
  localparam int unsigned CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    we_q, we_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          is_load_q, is_load_d;
  logic [31:0]   load_data_q, load_data_d;
  logic          bus_error_q, bus_error_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        sel_byte, sel_half, sel_word, sel_legal;
  logic        aligned, access, req_valid, misaligned;
  logic [3:0]  we_new;
  logic [31:0] wdata_new;
  logic        timed_out;

  // Decode the MEM-stage request: size legality, alignment and lane steering.
  always_comb begin
    sel_byte = (mem_sel == 4'b0001);
    sel_word = (mem_sel == 4'b1111);
`ifdef RAM_HALF_EN
    sel_half = (mem_sel == 4'b0011);
`else
    sel_half = 1'b0;
`endif
    sel_legal  = sel_byte | sel_half | sel_word;
    aligned    = sel_word ? (address[1:0] == 2'b00) :
                 sel_half ? (address[0] == 1'b0) : 1'b1;
    access     = (state_q == IDLE) & (mem_read_flag | mem_write_flag) &
                 sel_legal & !flush;
    req_valid  = access & aligned;
    misaligned = access & !aligned;
    we_new     = 4'b0000;
    wdata_new  = mem_write_data;
    if (mem_write_flag) begin
      if (sel_byte) begin
        we_new    = 4'b0001 << address[1:0];
        wdata_new = {4{mem_write_data[7:0]}};
      end else if (sel_half) begin
        we_new    = 4'b0011 << address[1:0];
        wdata_new = {2{mem_write_data[15:0]}};
      end else begin
        we_new    = 4'b1111;
      end
    end
  end

  // Next-state logic for the IDLE -> REQ -> DONE transaction sequence.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    is_load_d   = is_load_q;
    load_data_d = load_data_q;
    bus_error_d = 1'b0;
    cnt_d       = cnt_q;
    timed_out   = (ACK_TIMEOUT != 0) && (cnt_q == CW'(ACK_TIMEOUT - 1));
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d   = REQ;
          addr_d    = {address[31:2], 2'b00};
          we_d      = we_new;
          wdata_d   = wdata_new;
          is_load_d = !mem_write_flag;   // store wins when both flags are set
          cnt_d     = '0;
        end
      end
      REQ: begin
        if (ram.ram_ack) begin
          state_d = DONE;
          if (is_load_q) load_data_d = ram.ram_read_data;
        end else if (timed_out) begin
          state_d     = DONE;
          bus_error_d = 1'b1;
        end else if (ACK_TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // MEM inputs still describe the finished instruction here, so no
      // new request may be taken until the pipeline has advanced.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and transaction registers; reset aborts any in-flight request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= '0;
      wdata_q     <= '0;
      is_load_q   <= 1'b0;
      load_data_q <= '0;
      bus_error_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      is_load_q   <= is_load_d;
      load_data_q <= load_data_d;
      bus_error_q <= bus_error_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ram.ram_en         = (state_q == REQ);
  assign ram.ram_write_en   = we_q;
  assign ram.ram_addr       = addr_q;
  assign ram.ram_write_data = wdata_q;
  assign load_data          = load_data_q;
  assign bus_error          = bus_error_q;
  assign stall_req          = req_valid | (state_q == REQ);
  assign adel               = misaligned & !mem_write_flag;
  assign ades               = misaligned & mem_write_flag;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a short ack timeout.
module tb_ram_access_ctrl;

  localparam int unsigned TIMEOUT = 4;

  logic        clk;
  logic        rst;
  logic        mem_read_flag, mem_write_flag, flush;
  logic [3:0]  mem_sel;
  logic [31:0] address, mem_write_data;
  logic [31:0] load_data;
  logic        stall_req, adel, ades, bus_error;
  logic [1:0]  dbg_state;

  int checks;
  int errors;

  ram_access_ctrl_if ram_bus ();

  ram_access_ctrl #(.ACK_TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_read_flag  (mem_read_flag),
    .mem_write_flag (mem_write_flag),
    .mem_sel        (mem_sel),
    .address        (address),
    .mem_write_data (mem_write_data),
    .flush          (flush),
    .ram            (ram_bus),
    .load_data      (load_data),
    .stall_req      (stall_req),
    .adel           (adel),
    .ades           (ades),
    .bus_error      (bus_error),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        fl;
    int          k;          // REQ cycle carrying the ack (beyond timeout = late)
    logic [31:0] rdata;
    logic        exp_req;
    logic        exp_adel;
    logic        exp_ades;
    logic [31:0] exp_addr;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata;
    int          exp_en;
    int          exp_stall;
    logic [31:0] exp_load;
    logic        exp_berr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [3:0] sel,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic fl, input int k, input logic [31:0] rdata,
                              input logic exp_req, input logic exp_adel, input logic exp_ades,
                              input logic [31:0] exp_addr, input logic [3:0] exp_we,
                              input logic [31:0] exp_wdata, input int exp_en,
                              input int exp_stall, input logic [31:0] exp_load,
                              input logic exp_berr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.sel = sel; v.addr = addr; v.wd = wd; v.fl = fl;
    v.k = k; v.rdata = rdata; v.exp_req = exp_req; v.exp_adel = exp_adel;
    v.exp_ades = exp_ades; v.exp_addr = exp_addr; v.exp_we = exp_we;
    v.exp_wdata = exp_wdata; v.exp_en = exp_en; v.exp_stall = exp_stall;
    v.exp_load = exp_load; v.exp_berr = exp_berr;
    return v;
  endfunction

  task automatic clear_inputs();
    mem_read_flag  = 1'b0;
    mem_write_flag = 1'b0;
    mem_sel        = 4'b0000;
    address        = '0;
    mem_write_data = '0;
    flush          = 1'b0;
    ram_bus.ram_ack       = 1'b0;
    ram_bus.ram_read_data = '0;
  endtask

  // driver: apply one vector and follow it through to IDLE
  task automatic run_vec(input vec_t v, input int idx);
    int  en_cnt;
    int  st_cnt;
    bit  done_seen;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(posedge clk); #1;
    mem_read_flag  = v.rd;
    mem_write_flag = v.wr;
    mem_sel        = v.sel;
    address        = v.addr;
    mem_write_data = v.wd;
    flush          = v.fl;
    @(negedge clk);
    check({tag, "_stall0"}, {31'd0, stall_req}, {31'd0, v.exp_req});
    check({tag, "_adel"},   {31'd0, adel},      {31'd0, v.exp_adel});
    check({tag, "_ades"},   {31'd0, ades},      {31'd0, v.exp_ades});
    check({tag, "_en0"},    {31'd0, ram_bus.ram_en}, 32'd0);
    if (v.exp_req) begin
      st_cnt = 1;
      en_cnt = 0;
      done_seen = 1'b0;
      for (int i = 1; i <= 20 && !done_seen; i++) begin
        @(posedge clk); #1;
        ram_bus.ram_ack       = (i == v.k);
        ram_bus.ram_read_data = (i == v.k) ? v.rdata : 32'h0BAD_0BAD;
        @(negedge clk);
        if (ram_bus.ram_en) begin
          en_cnt++;
          if (i == 1) begin
            check({tag, "_addr"}, ram_bus.ram_addr, v.exp_addr);
            check({tag, "_we"},   {28'd0, ram_bus.ram_write_en}, {28'd0, v.exp_we});
            if (v.wr) check({tag, "_wdata"}, ram_bus.ram_write_data, v.exp_wdata);
          end
        end
        if (stall_req) st_cnt++;
        if (!ram_bus.ram_en) done_seen = 1'b1;
      end
      check({tag, "_done_reached"}, {31'd0, done_seen}, 32'd1);
      check({tag, "_en_cycles"},    en_cnt, v.exp_en);
      check({tag, "_stall_cycles"}, st_cnt, v.exp_stall);
      check({tag, "_done_state"},   {30'd0, dbg_state}, 32'd2);
      check({tag, "_berr"},         {31'd0, bus_error}, {31'd0, v.exp_berr});
    end
    check({tag, "_load"}, load_data, v.exp_load);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    check({tag, "_idle_state"}, {30'd0, dbg_state}, 32'd0);
    check({tag, "_idle_en"},    {31'd0, ram_bus.ram_en}, 32'd0);
    check({tag, "_idle_berr"},  {31'd0, bus_error}, 32'd0);
    check({tag, "_idle_load"},  load_data, v.exp_load);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    clear_inputs();

    //        rd wr sel      addr          wd            fl k rdata
    //        req adel ades exp_addr      we       wdata         en st load          berr
    vecs.push_back(mk(0, 1, 4'b1111, 32'h100, 32'hDEADBEEF, 0, 1, 32'h0,
                      1, 0, 0, 32'h100, 4'b1111, 32'hDEADBEEF, 1, 2, 32'h0, 0));
    vecs.push_back(mk(0, 1, 4'b0001, 32'h203, 32'h000000A5, 0, 2, 32'h0,
                      1, 0, 0, 32'h200, 4'b1000, 32'hA5A5A5A5, 2, 3, 32'h0, 0));
    vecs.push_back(mk(1, 0, 4'b1111, 32'h40, 32'h0, 0, 3, 32'h12345678,
                      1, 0, 0, 32'h40, 4'b0000, 32'h0, 3, 4, 32'h12345678, 0));
    vecs.push_back(mk(1, 0, 4'b1111, 32'h42, 32'h0, 0, 1, 32'h0,
                      0, 1, 0, 32'h0, 4'b0000, 32'h0, 0, 0, 32'h12345678, 0));
    vecs.push_back(mk(0, 1, 4'b1111, 32'h41, 32'h11111111, 0, 1, 32'h0,
                      0, 0, 1, 32'h0, 4'b0000, 32'h0, 0, 0, 32'h12345678, 0));
`ifdef RAM_HALF_EN
    vecs.push_back(mk(0, 1, 4'b0011, 32'h6, 32'h0000BEEF, 0, 1, 32'h0,
                      1, 0, 0, 32'h4, 4'b1100, 32'hBEEFBEEF, 1, 2, 32'h12345678, 0));
    vecs.push_back(mk(0, 1, 4'b0011, 32'h5, 32'h0000BEEF, 0, 1, 32'h0,
                      0, 0, 1, 32'h0, 4'b0000, 32'h0, 0, 0, 32'h12345678, 0));
`else
    vecs.push_back(mk(0, 1, 4'b0011, 32'h6, 32'h0000BEEF, 0, 1, 32'h0,
                      0, 0, 0, 32'h0, 4'b0000, 32'h0, 0, 0, 32'h12345678, 0));
    vecs.push_back(mk(0, 1, 4'b0011, 32'h5, 32'h0000BEEF, 0, 1, 32'h0,
                      0, 0, 0, 32'h0, 4'b0000, 32'h0, 0, 0, 32'h12345678, 0));
`endif
    // timeout: ack arrives one cycle late, in DONE, and must be ignored
    vecs.push_back(mk(1, 0, 4'b1111, 32'h80, 32'h0, 0, 5, 32'hCAFEF00D,
                      1, 0, 0, 32'h80, 4'b0000, 32'h0, 4, 5, 32'h12345678, 1));
    vecs.push_back(mk(1, 0, 4'b0001, 32'h11, 32'h0, 0, 1, 32'h55667788,
                      1, 0, 0, 32'h10, 4'b0000, 32'h0, 1, 2, 32'h55667788, 0));
    vecs.push_back(mk(0, 1, 4'b0111, 32'h20, 32'h12345678, 0, 1, 32'h0,
                      0, 0, 0, 32'h0, 4'b0000, 32'h0, 0, 0, 32'h55667788, 0));
    vecs.push_back(mk(1, 0, 4'b1111, 32'h44, 32'h0, 1, 1, 32'h0,
                      0, 0, 0, 32'h0, 4'b0000, 32'h0, 0, 0, 32'h55667788, 0));
    vecs.push_back(mk(1, 1, 4'b1111, 32'h2, 32'h0, 0, 1, 32'h0,
                      0, 0, 1, 32'h0, 4'b0000, 32'h0, 0, 0, 32'h55667788, 0));
    vecs.push_back(mk(1, 1, 4'b0001, 32'h21, 32'h0000003C, 0, 1, 32'hFFFFFFFF,
                      1, 0, 0, 32'h20, 4'b0010, 32'h3C3C3C3C, 1, 2, 32'h55667788, 0));
    vecs.push_back(mk(1, 1, 4'b1111, 32'h41, 32'h0, 1, 1, 32'h0,
                      0, 0, 0, 32'h0, 4'b0000, 32'h0, 0, 0, 32'h55667788, 0));

    // reset state
    @(negedge clk);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    check("rst_en",    {31'd0, ram_bus.ram_en}, 32'd0);
    check("rst_we",    {28'd0, ram_bus.ram_write_en}, 32'd0);
    check("rst_addr",  ram_bus.ram_addr, 32'd0);
    check("rst_wdata", ram_bus.ram_write_data, 32'd0);
    check("rst_load",  load_data, 32'd0);
    check("rst_misc",  {28'd0, stall_req, adel, ades, bus_error}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // flush raised while in REQ must not abort the transaction
    @(posedge clk); #1;
    mem_write_flag = 1'b1; mem_sel = 4'b1111; address = 32'h400;
    mem_write_data = 32'h11223344;
    @(posedge clk); #1;
    flush = 1'b1;
    ram_bus.ram_ack = 1'b1;
    @(negedge clk);
    check("flreq_en",   {31'd0, ram_bus.ram_en}, 32'd1);
    check("flreq_addr", ram_bus.ram_addr, 32'h400);
    @(posedge clk); #1;
    ram_bus.ram_ack = 1'b0;
    @(negedge clk);
    check("flreq_done", {30'd0, dbg_state}, 32'd2);
    @(posedge clk); #1;
    clear_inputs();

    // asynchronous reset mid-REQ drops ram_en at once; later ack is discarded
    @(posedge clk); #1;
    mem_read_flag = 1'b1; mem_sel = 4'b1111; address = 32'h300;
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    check("mrst_req_en", {31'd0, ram_bus.ram_en}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mrst_en",    {31'd0, ram_bus.ram_en}, 32'd0);
    check("mrst_state", {30'd0, dbg_state}, 32'd0);
    check("mrst_load",  load_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    ram_bus.ram_ack = 1'b1;
    ram_bus.ram_read_data = 32'h99999999;
    @(posedge clk); #1;
    ram_bus.ram_ack = 1'b0;
    @(negedge clk);
    check("mrst_post_state", {30'd0, dbg_state}, 32'd0);
    check("mrst_post_load",  load_data, 32'd0);
    check("mrst_post_en",    {31'd0, ram_bus.ram_en}, 32'd0);

    // report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Data-RAM initiator for the MEM stage: turns load/store requests into a single RAM transaction with byte write enables and lane-replicated store data. It stalls the pipeline until the RAM acknowledges, then latches load data for WB, which extracts and extends bytes. It flags misaligned accesses and RAM timeouts instead of issuing them.

## Interface
- ACK_TIMEOUT, 255: max cycles waited for ram_ack in REQ; 0 disables timeout.
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- mem_read_flag  input  1  load request from MEM stage
- mem_write_flag  input  1  store request from MEM stage
- mem_sel  input  4  access size: 4'b0001 byte, 4'b1111 word, 4'b0011 halfword (only with RAM_HALF_EN)
- address  input  32  byte address of access
- mem_write_data  input  32  store data, right-aligned
- flush  input  1  squash current MEM-stage request (IDLE only)
- ram_ack  input  1  one-cycle RAM completion pulse
- ram_read_data  input  32  RAM read word, valid with ram_ack
- ram_en  output  1  RAM request, held until ack
- ram_write_en  output  4  byte write enables, 0 for loads
- ram_addr  output  32  word-aligned address {address[31:2],2'b00}
- ram_write_data  output  32  lane-replicated store data
- load_data  output  32  read word latched on ram_ack
- stall_req  output  1  hold pipeline
- adel  output  1  load address error
- ades  output  1  store address error
- bus_error  output  1  one-cycle pulse on ack timeout

## Operation
- States: IDLE, REQ, DONE.
- Valid request: (mem_read_flag | mem_write_flag) & legal mem_sel & aligned & !flush, sampled in IDLE. Both flags set: store wins.
- Alignment: word needs address[1:0]==0; halfword needs address[0]==0; byte always aligned.
- Misaligned in IDLE (no flush): combinational adel (load) or ades (store); no RAM request, stall_req low, stays IDLE.
- Illegal mem_sel: no request, no exception, stays IDLE.
- IDLE -> REQ on valid request: register ram_addr, ram_write_en, ram_write_data, op type; clear timeout counter.
- Enables: byte 4'b0001<<address[1:0], data {4{d[7:0]}}; halfword 4'b0011<<address[1:0], data {2{d[15:0]}}; word 4'b1111, data unchanged.
- REQ: ram_en=1, outputs stable. On ram_ack -> DONE; loads latch ram_read_data into load_data. Counter increments per REQ cycle without ack; at ACK_TIMEOUT (nonzero) -> DONE with bus_error pulse, ram_en dropped, load_data unchanged.
- DONE: ram_en=0, stall_req=0, unconditionally -> IDLE; no new request accepted (MEM inputs still hold completed instruction).
- ram_ack outside REQ ignored. flush in REQ/DONE ignored; transaction completes.
- load_data holds until next load ack.

## Timing
- Reset: state IDLE; ram_en, ram_write_en, ram_addr, ram_write_data, load_data, bus_error, counter = 0; stall_req, adel, ades = 0.
- Reset mid-REQ drops ram_en asynchronously; pending ack discarded.
- stall_req = (IDLE & valid request) | REQ; combinational.
- Request accepted cycle N; ram_en high from N+1 through ack cycle; ack at N+k -> DONE at N+k+1, load_data valid then; pipeline advances end of N+k+1. Minimum stall: 2 cycles (k=1).
- Timeout: bus_error high exactly in DONE cycle after ACK_TIMEOUT un-acked REQ cycles.

## Configuration
- RAM_HALF_EN defined: mem_sel 4'b0011 legal halfword access with alignment check on address[0].
- Undefined: 4'b0011 illegal (no request, no exception), like any other unlisted mem_sel.

## Test plan
- Word store addr 0x100, data 0xDEADBEEF, ack 1 cycle later -> ram_addr 0x100, ram_write_en 4'b1111, data 0xDEADBEEF, stall 2 cycles.
- Byte store addr 0x203, data 0x000000A5 -> ram_addr 0x200, ram_write_en 4'b1000, ram_write_data 0xA5A5A5A5.
- Word load addr 0x40, ack after 3 REQ cycles with 0x12345678 -> ram_en 3 cycles, load_data 0x12345678 in DONE, stall 4 cycles.
- Word load addr 0x42 -> adel=1 same cycle, ram_en 0, stall 0; word store addr 0x41 -> ades=1.
- ACK_TIMEOUT=4, no ack -> ram_en 4 cycles, bus_error pulse 1 cycle, back to IDLE; late ack ignored.
- Halfword store addr 0x6, data 0xBEEF with RAM_HALF_EN -> ram_write_en 4'b1100, data 0xBEEFBEEF; without macro -> no request.
